// File: rtl/riscv_div_pkg.sv
// Shared defines for the RV32M divider: funct3 codes, FSM state encoding, op decode.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package riscv_div_pkg;

  // RV32M divide-family funct3 codes (also consumed by the ALU decode)
  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned CNT_W    = 6;
  localparam logic [5:0]  LAST_ITER = 6'd31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  typedef struct packed {
    logic is_signed;
    logic is_rem;
  } div_op_t;

  // Any code outside the four divide ops behaves as DIVU.
  function automatic div_op_t decode_op(input logic [2:0] funct3);
    div_op_t op;
    op = '{is_signed: 1'b0, is_rem: 1'b0};
    case (funct3)
      F3_DIV:  op = '{is_signed: 1'b1, is_rem: 1'b0};
      F3_REM:  op = '{is_signed: 1'b1, is_rem: 1'b1};
      F3_REMU: op = '{is_signed: 1'b0, is_rem: 1'b1};
      default: op = '{is_signed: 1'b0, is_rem: 1'b0};
    endcase
    return op;
  endfunction

endpackage

// File: rtl/riscv_div_step.sv
// One radix-2 restoring iteration: shift in the next dividend bit, trial-subtract divisor.
// Latency: purely combinational.
// Backpressure: none; ports: rem_i/div_i/bit_i in, rem_o/q_bit_o out.
module riscv_div_step
  import riscv_div_pkg::*;
(
  input  logic [XLEN:0]   rem_i,    // 33-bit partial remainder (MSB always 0 between steps)
  input  logic [XLEN-1:0] div_i,    // divisor magnitude
  input  logic            bit_i,    // next dividend bit, MSB first
  output logic [XLEN:0]   rem_o,    // next partial remainder
  output logic            q_bit_o   // quotient bit produced by this step
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          unused_rem_msb;

  // The remainder is always below the divisor, so its MSB is zero on entry
  // and is dropped by the shift.
  assign unused_rem_msb = rem_i[XLEN];

  assign shifted = {rem_i[XLEN-1:0], bit_i};
  assign diff    = shifted - {1'b0, div_i};

  // A borrow out of the subtract (bit 32 set) means divisor did not fit: restore.
  assign q_bit_o = ~diff[XLEN];
  assign rem_o   = diff[XLEN] ? shifted : diff;

endmodule

// File: rtl/riscv_div.sv
// RV32M DIV/DIVU/REM/REMU: iterative restoring divider, one quotient bit per cycle.
// Latency: valid_o 32 cycles after the accepting edge; 0 extra for div-by-zero/overflow fast paths.
// Backpressure: start_i accepted only while ready_o=1, otherwise dropped; flush_i aborts.
// Ports: clk_i, rst_i (async high), start_i, flush_i, funct3_i, data_a_i, data_b_i in;
//        ready_o, busy_o, valid_o, result_o out.
module riscv_div
  import riscv_div_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] data_a_i,
  input  logic [XLEN-1:0] data_b_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             is_rem_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic [XLEN-1:0]  divisor_q;
  logic [XLEN-1:0]  quo_q;     // dividend bits shift out of the top, quotient bits in at the bottom
  logic [XLEN:0]    rem_q;
  logic [XLEN-1:0]  result_q;

  // Operand decode at acceptance
  div_op_t          op_in;
  logic             sign_a, sign_b;
  logic [XLEN-1:0]  abs_a, abs_b;
  logic             div_zero, sgn_ovf;
  logic             accept;

  // Iteration datapath
  logic [XLEN:0]    step_rem;
  logic             step_qbit;
  logic [XLEN-1:0]  quo_fin, rem_fin, result_fin;

  assign op_in    = decode_op(funct3_i);
  assign sign_a   = op_in.is_signed & data_a_i[XLEN-1];
  assign sign_b   = op_in.is_signed & data_b_i[XLEN-1];
  assign abs_a    = sign_a ? -data_a_i : data_a_i;
  assign abs_b    = sign_b ? -data_b_i : data_b_i;
  assign div_zero = (data_b_i == '0);
  assign sgn_ovf  = op_in.is_signed && (data_a_i == 32'h8000_0000) && (data_b_i == 32'hFFFF_FFFF);
  assign accept   = (state_q == ST_IDLE) && start_i && !flush_i;

  riscv_div_step u_step (
    .rem_i   (rem_q),
    .div_i   (divisor_q),
    .bit_i   (quo_q[XLEN-1]),
    .rem_o   (step_rem),
    .q_bit_o (step_qbit)
  );

  // Values as they stand after the final iteration, with sign fixup.
  // Sign flags were already cleared for unsigned ops at acceptance.
  assign quo_fin    = {quo_q[XLEN-2:0], step_qbit};
  assign rem_fin    = step_rem[XLEN-1:0];
  assign result_fin = is_rem_q ? (neg_rem_q ? -rem_fin : rem_fin)
                               : (neg_quo_q ? -quo_fin : quo_fin);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state and status outputs
  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    busy_o  = 1'b0;
    valid_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_o = 1'b1;
        if (start_i) state_d = (div_zero || sgn_ovf) ? ST_DONE : ST_CALC;
      end
      ST_CALC: begin
        busy_o = 1'b1;
        if (cnt_q == LAST_ITER) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy_o  = 1'b1;
        valid_o = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush_i) state_d = ST_IDLE;
  end

  // Datapath
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      divisor_q <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      result_q  <= '0;
    end else if (flush_i) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q     <= '0;
      is_rem_q  <= op_in.is_rem;
      neg_quo_q <= sign_a ^ sign_b;
      neg_rem_q <= sign_a;
      divisor_q <= abs_b;
      quo_q     <= abs_a;
      rem_q     <= '0;
      // Divide-by-zero is checked first so it wins over signed overflow.
      if (div_zero)     result_q <= op_in.is_rem ? data_a_i : 32'hFFFF_FFFF;
      else if (sgn_ovf) result_q <= op_in.is_rem ? 32'h0 : 32'h8000_0000;
    end else if (state_q == ST_CALC) begin
      rem_q <= step_rem;
      quo_q <= {quo_q[XLEN-2:0], step_qbit};
      cnt_q <= cnt_q + 6'd1;
      if (cnt_q == LAST_ITER) result_q <= result_fin;
    end
  end

  assign result_o = result_q;

endmodule

// File: tb/tb_riscv_div.sv
module tb_riscv_div;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [2:0]  funct3_i = 3'b0;
  logic [31:0] data_a_i = '0;
  logic [31:0] data_b_i = '0;
  logic        ready_o, busy_o, valid_o;
  logic [31:0] result_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   op_id = 0;

  riscv_div dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .flush_i  (flush_i),
    .funct3_i (funct3_i),
    .data_a_i (data_a_i),
    .data_b_i (data_b_i),
    .ready_o  (ready_o),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .result_o (result_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Behavioural reference: RISC-V M-extension semantics with plain arithmetic.
  function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int  sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'b100:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      3'b110:  return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      3'b111:  return (b == 0) ? a : a % b;
      default: return (b == 0) ? 32'hFFFF_FFFF : a / b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bit sgn;
    sgn = (f3 == 3'b100) || (f3 == 3'b110);
    return (b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input bit expect_result);
    exp_t e;
    int   n;
    n = 0;
    while (!ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (!ready_o) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: ready_o=%b, expected 1", ready_o);
    end
    funct3_i = f3;
    data_a_i = a;
    data_b_i = b;
    start_i  = 1'b1;
    if (expect_result) begin
      e.res = ref_div(f3, a, b);
      e.cyc = cyc + 1 + (is_fast(f3, a, b) ? 0 : 32);
      e.id  = op_id;
      sb.push_back(e);
    end
    op_id++;
    @(negedge clk_i);
    start_i  = 1'b0;
    // Operands are scrambled afterwards; the result must not depend on them.
    funct3_i = 3'($urandom);
    data_a_i = $urandom;
    data_b_i = $urandom;
  endtask

  // Scoreboard monitor
  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_i && valid_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got valid_o=1 result=%h, expected no completion", result_o);
      end else begin
        e = sb.pop_front();
        chk($sformatf("result op%0d", e.id), result_o, e.res);
        chk($sformatf("latency op%0d", e.id), 32'(cyc), 32'(e.cyc));
        chk($sformatf("busy_in_done op%0d", e.id), {31'b0, busy_o}, 32'd1);
      end
    end
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    int          n;

    // Reset state, visible without any clock edge
    #3;
    chk("rst_ready", {31'b0, ready_o}, 32'd1);
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_valid", {31'b0, valid_o}, 32'd0);
    chk("rst_result", result_o, 32'h0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Directed cases; the first start follows reset release directly
    issue(3'b100, 32'd20, 32'hFFFF_FFFD, 1);
    issue(3'b110, 32'd20, 32'hFFFF_FFFD, 1);
    issue(3'b101, 32'hFFFF_FFFF, 32'd2, 1);
    issue(3'b111, 32'hFFFF_FFF9, 32'd2, 1);
    issue(3'b110, 32'hFFFF_FFF9, 32'd2, 1);
    issue(3'b100, 32'h1234_5678, 32'd0, 1);
    issue(3'b111, 32'h1234_5678, 32'd0, 1);
    issue(3'b110, 32'h8000_0000, 32'd0, 1);   // zero beats overflow
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    // Start during DONE must be dropped
    funct3_i = 3'b101; data_a_i = 32'd99; data_b_i = 32'd3; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    issue(3'b011, 32'd1000, 32'd7, 1);        // unlisted code behaves as DIVU
    // Start during CALC must be dropped
    repeat (3) @(negedge clk_i);
    chk("busy_calc", {31'b0, busy_o}, 32'd1);
    chk("ready_calc", {31'b0, ready_o}, 32'd0);
    funct3_i = 3'b100; data_a_i = 32'd5; data_b_i = 32'd0; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;

    // Flush at iteration 10: no completion, back to IDLE
    issue(3'b100, 32'd12345, 32'd17, 0);
    repeat (9) @(negedge clk_i);
    flush_i = 1'b1;
    start_i = 1'b1;                            // flush wins over start
    @(negedge clk_i);
    flush_i = 1'b0;
    start_i = 1'b0;
    chk("flush_ready", {31'b0, ready_o}, 32'd1);
    chk("flush_busy", {31'b0, busy_o}, 32'd0);
    chk("flush_result_held", result_o, 32'd142);
    @(negedge clk_i);
    chk("flush_start_ignored", {31'b0, ready_o}, 32'd1);

    // Asynchronous reset at iteration 5 of a new op
    issue(3'b101, 32'd555, 32'd5, 0);
    repeat (4) @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_ready", {31'b0, ready_o}, 32'd1);
    chk("arst_busy", {31'b0, busy_o}, 32'd0);
    chk("arst_result", result_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    issue(3'b101, 32'd100, 32'd7, 1);
    repeat (5) @(negedge clk_i);
    chk("result_zero_until_done", result_o, 32'h0);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'h0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF;
        3:       b = -$urandom_range(1, 15);
        default: b = $urandom;
      endcase
      issue(f3, a, b, 1);
    end

    // Drain
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    repeat (3) @(negedge clk_i);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
